// File: rtl/shift_ctrl_pkg.sv
// Shared codes for the shift sequencer: ops, commands, selectors, states.
package shift_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_SLL  = 3'b000,
    OP_SRL  = 3'b001,
    OP_SRA  = 3'b010,
    OP_SLLV = 3'b011,
    OP_SRLV = 3'b100,
    OP_SRAV = 3'b101,
    OP_LUI  = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  localparam logic [2:0] CMD_NOP  = 3'b000;
  localparam logic [2:0] CMD_LOAD = 3'b001;
  localparam logic [2:0] CMD_LEFT = 3'b010;
  localparam logic [2:0] CMD_RLOG = 3'b011;
  localparam logic [2:0] CMD_RARI = 3'b100;

  localparam logic [1:0] SA_INSTR = 2'b00;
  localparam logic [1:0] SA_16    = 2'b01;
  localparam logic [1:0] SA_REGB  = 2'b10;

  localparam logic [1:0] SRC_REGB = 2'b00;
  localparam logic [1:0] SRC_IMM  = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_LOAD  = 2'b01,
    S_SHIFT = 2'b10,
    S_WB    = 2'b11
  } state_e;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational decode of a shift op into selectors and shift direction.
module shift_op_decode
  import shift_ctrl_pkg::*;
(
  input  logic [2:0] op,
  output logic       legal,
  output logic [1:0] shamt_sel,
  output logic [1:0] src_sel,
  output logic [2:0] shift_cmd
);

  always_comb begin
    legal     = 1'b1;
    shamt_sel = SA_INSTR;
    src_sel   = SRC_REGB;
    shift_cmd = CMD_LEFT;
    unique case (op)
      OP_SLL:  shift_cmd = CMD_LEFT;
      OP_SRL:  shift_cmd = CMD_RLOG;
      OP_SRA:  shift_cmd = CMD_RARI;
      OP_SLLV: begin
        shamt_sel = SA_REGB;
        shift_cmd = CMD_LEFT;
      end
      OP_SRLV: begin
        shamt_sel = SA_REGB;
        shift_cmd = CMD_RLOG;
      end
      OP_SRAV: begin
        shamt_sel = SA_REGB;
        shift_cmd = CMD_RARI;
      end
      OP_LUI: begin
        shamt_sel = SA_16;
        src_sel   = SRC_IMM;
        shift_cmd = CMD_LEFT;
      end
      default: begin
        legal     = 1'b0;
        shift_cmd = CMD_NOP;
      end
    endcase
  end

endmodule

// File: rtl/shift_ctrl.sv
// Multicycle shift sequencer: IDLE -> LOAD -> SHIFT -> WB.
// Define SHIFT_ZERO_BYPASS_EN to skip SHIFT when the amount is zero.
module shift_ctrl
  import shift_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_op,
  output logic       req_ready,
  input  logic [4:0] shamt,
  output logic [1:0] shamt_sel,
  output logic [1:0] src_sel,
  output logic [2:0] shft_cmd,
  output logic       rd_we,
  output logic       busy,
  output logic       illegal
);

  state_e     state;
  logic [2:0] op_q;
  logic       dec_legal;
  logic [1:0] dec_shamt_sel;
  logic [1:0] dec_src_sel;
  logic [2:0] dec_cmd;
  logic       zero_skip;

  shift_op_decode u_dec (
    .op        (op_q),
    .legal     (dec_legal),
    .shamt_sel (dec_shamt_sel),
    .src_sel   (dec_src_sel),
    .shift_cmd (dec_cmd)
  );

`ifdef SHIFT_ZERO_BYPASS_EN
  // LUI always shifts by the constant 16, never by shamt
  assign zero_skip = (shamt == 5'd0) && (op_q != OP_LUI);
`else
  logic unused_shamt;
  assign unused_shamt = ^shamt;
  assign zero_skip    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= 3'b000;
      illegal <= 1'b0;
    end else begin
      illegal <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (req_op == OP_ILL) begin
              illegal <= 1'b1;
            end else begin
              op_q  <= req_op;
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (!dec_legal)     state <= S_IDLE;
          else if (zero_skip) state <= S_WB;
          else                state <= S_SHIFT;
        end
        S_SHIFT: state <= S_WB;
        S_WB:    state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    busy      = (state != S_IDLE);
    rd_we     = (state == S_WB);
    shamt_sel = busy ? dec_shamt_sel : SA_INSTR;
    src_sel   = busy ? dec_src_sel : SRC_REGB;
    shft_cmd  = CMD_NOP;
    unique case (state)
      S_IDLE:  shft_cmd = CMD_NOP;
      S_LOAD:  shft_cmd = CMD_LOAD;
      S_SHIFT: shft_cmd = dec_cmd;
      S_WB:    shft_cmd = CMD_NOP;
    endcase
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed + random bench for shift_ctrl against a per-cycle expectation queue.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [2:0] req_op;
  logic       req_ready;
  logic [4:0] shamt;
  logic [1:0] shamt_sel;
  logic [1:0] src_sel;
  logic [2:0] shft_cmd;
  logic       rd_we;
  logic       busy;
  logic       illegal;

  int checks = 0;
  int failures = 0;

`ifdef SHIFT_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  shift_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_ready (req_ready),
    .shamt     (shamt),
    .shamt_sel (shamt_sel),
    .src_sel   (src_sel),
    .shft_cmd  (shft_cmd),
    .rd_we     (rd_we),
    .busy      (busy),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // {ready, busy, shamt_sel, src_sel, shft_cmd, rd_we, illegal}
  typedef logic [10:0] obs_t;

  localparam obs_t IDLE_O = 11'b1_0_00_00_000_0_0;
  localparam obs_t ILL_O  = 11'b1_0_00_00_000_0_1;

  obs_t expq[$];
  obs_t cur;

  function automatic obs_t busy_o(logic [1:0] ss, logic [1:0] src,
                                  logic [2:0] cmd, logic we);
    return {1'b0, 1'b1, ss, src, cmd, we, 1'b0};
  endfunction

  task automatic check(string tag, obs_t exp);
    obs_t obs;
    obs = {req_ready, busy, shamt_sel, src_sel, shft_cmd, rd_we, illegal};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  // Model: an accepted op expands into its list of per-cycle outputs.
  task automatic plan(logic [2:0] op, logic [4:0] sa);
    logic [1:0] ss;
    logic [1:0] src;
    logic [2:0] dir;
    int opi;
    opi = int'(op);
    if (opi <= 2) begin
      ss = 2'b00; src = 2'b00;
    end else if (opi <= 5) begin
      ss = 2'b10; src = 2'b00;
    end else begin
      ss = 2'b01; src = 2'b01;
    end
    if (opi == 0 || opi == 3 || opi == 6) dir = 3'b010;
    else if (opi == 1 || opi == 4)        dir = 3'b011;
    else                                  dir = 3'b100;
    expq.push_back(busy_o(ss, src, 3'b001, 1'b0));
    if (!(BYP && sa == 5'd0 && opi != 6))
      expq.push_back(busy_o(ss, src, dir, 1'b0));
    expq.push_back(busy_o(ss, src, 3'b000, 1'b1));
  endtask

  task automatic step(logic v, logic [2:0] op, logic [4:0] sa, string tag);
    req_valid = v;
    req_op    = op;
    shamt     = sa;
    if (v && cur[10]) begin
      if (op == 3'b111) expq.push_back(ILL_O);
      else              plan(op, sa);
    end
    @(posedge clk);
    #1;
    cur = (expq.size() != 0) ? expq.pop_front() : IDLE_O;
    check(tag, cur);
  endtask

  initial begin
    logic [4:0] hold_sa;
    logic [2:0] rop;
    logic       rv;
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'b000;
    shamt     = 5'd0;
    cur       = IDLE_O;
    #1;
    check("reset_async", IDLE_O);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", IDLE_O);
    reset = 1'b0;

    // SLL
    step(1'b1, 3'b000, 5'd5, "sll_load");
    step(1'b0, 3'b000, 5'd5, "sll_shift");
    step(1'b0, 3'b000, 5'd5, "sll_wb");
    step(1'b0, 3'b000, 5'd5, "sll_idle");

    // LUI, amount input zero: SHIFT still visited
    step(1'b1, 3'b110, 5'd0, "lui_load");
    step(1'b0, 3'b110, 5'd0, "lui_shift");
    step(1'b0, 3'b110, 5'd0, "lui_wb");
    step(1'b0, 3'b110, 5'd0, "lui_idle");

    // SRLV with zero amount
    step(1'b1, 3'b100, 5'd0, "srlv0_load");
    step(1'b0, 3'b100, 5'd0, "srlv0_c2");
    step(1'b0, 3'b100, 5'd0, "srlv0_c3");
    step(1'b0, 3'b100, 5'd0, "srlv0_c4");

    // Illegal then an immediate legal request
    step(1'b1, 3'b111, 5'd3, "ill_pulse");
    step(1'b1, 3'b001, 5'd3, "ill_next_load");
    step(1'b0, 3'b001, 5'd3, "ill_next_shift");
    step(1'b0, 3'b001, 5'd3, "ill_next_wb");
    step(1'b0, 3'b001, 5'd3, "ill_next_idle");

    // Back-to-back with req_valid held
    step(1'b1, 3'b010, 5'd7, "b2b_sra_load");
    for (int i = 0; i < 7; i++)
      step(1'b1, 3'b011, 5'd7, $sformatf("b2b_c%0d", i + 2));
    step(1'b0, 3'b011, 5'd7, "b2b_idle");

    // Reset while an SRAV is in SHIFT
    step(1'b1, 3'b101, 5'd9, "rst_srav_load");
    step(1'b0, 3'b101, 5'd9, "rst_srav_shift");
    reset = 1'b1;
    #1;
    check("rst_mid_async", IDLE_O);
    expq.delete();
    cur = IDLE_O;
    @(posedge clk);
    #1;
    check("rst_mid_hold", IDLE_O);
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      step(1'b0, 3'b101, 5'd9, $sformatf("rst_after_%0d", i));

    // Random traffic
    hold_sa = 5'd1;
    for (int i = 0; i < 400; i++) begin
      rv  = ($urandom_range(0, 2) != 0);
      rop = 3'($urandom_range(0, 7));
      if (cur[10])
        hold_sa = ($urandom_range(0, 3) == 0) ? 5'd0
                                              : 5'($urandom_range(1, 31));
      step(rv, rop, hold_sa, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
